// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a registered carry,
// LSB first, WIDTH clocks per operation, with a start/busy/done handshake.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   // A one-bit counter is kept for WIDTH=1 so the vector is never zero-width.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             sum_bit_s;
   logic             cout_s;
   logic [WIDTH:0]   res_cat_s;

   // Full-adder cell on the current LSBs; result register shifts in from the MSB end.
   always_comb begin
      sum_bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      cout_s    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
      res_cat_s = {sum_bit_s, res_sh_q};
   end

   // Next-state and datapath update; s/co/ovf only change on the final bit.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      s_d      = s_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      co_d     = co_q;
      ovf_d    = ovf_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               // Subtract is A + ~B + ~ci, so the borrow-in becomes an inverted carry-in.
               a_sh_d  = A;
               b_sh_d  = sub ? ~B : B;
               carry_d = ci ^ sub;
               cnt_d   = {CW{1'b0}};
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = cout_s;
            res_sh_d = res_cat_s[WIDTH:1];
            if (cnt_q == LAST) begin
               // carry_q here is the carry into the MSB.
               s_d     = res_cat_s[WIDTH:1];
               co_d    = cout_s;
               ovf_d   = carry_q ^ cout_s;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN)  ? 1'b1 : 1'b0;
      done_d = (state_d == ST_DONE) ? 1'b1 : 1'b0;
   end

   // State and datapath registers with synchronous reset that aborts any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= {WIDTH{1'b0}};
         b_sh_q   <= {WIDTH{1'b0}};
         res_sh_q <= {WIDTH{1'b0}};
         s_q      <= {WIDTH{1'b0}};
         cnt_q    <= {CW{1'b0}};
         carry_q  <= 1'b0;
         co_q     <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         s_q      <= s_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         co_q     <= co_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign co   = co_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder: WIDTH=8 instance plus a WIDTH=1 instance.
module tb_serial_adder;

   logic       clk;
   logic       rst;
   logic       start, sub, ci;
   logic [7:0] a, b;
   logic       busy, done, co, ovf;
   logic [7:0] s;

   logic       start1, sub1, ci1, a1, b1;
   logic       busy1, done1, s1, co1, ovf1;

   int n_cmp;
   int n_bad;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .A(a), .B(b), .ci(ci),
      .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub1), .A(a1), .B(b1), .ci(ci1),
      .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Step to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one 8-bit op from the current cycle and wait for done (bounded).
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input logic sv, output int bcyc, output bit got);
      start = 1'b1; a = av; b = bv; ci = cv; sub = sv;
      step();
      start = 1'b0;
      bcyc = 0;
      got  = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (busy) bcyc++;
         if (done) got = 1'b1;
         else step();
      end
   endtask

   // Full check of an 8-bit op: latency, handshake and result.
   task automatic check_op(input string nm, input logic [7:0] av, input logic [7:0] bv,
                           input logic cv, input logic sv, input logic [7:0] es,
                           input logic eco, input logic eovf);
      int bcyc;
      bit got;
      run_op(av, bv, cv, sv, bcyc, got);
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL %s done_timeout: no done within 20 cycles", nm); end
      n_cmp++;
      if (bcyc !== 8) begin n_bad++; $display("FAIL %s busy_cycles: got %0d want 8", nm, bcyc); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_in_done: got %b want 0", nm, busy); end
      n_cmp++;
      if (s !== es) begin n_bad++; $display("FAIL %s s: got %h want %h", nm, s, es); end
      n_cmp++;
      if (co !== eco) begin n_bad++; $display("FAIL %s co: got %b want %b", nm, co, eco); end
      n_cmp++;
      if (ovf !== eovf) begin n_bad++; $display("FAIL %s ovf: got %b want %b", nm, ovf, eovf); end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = 8'h00; b = 8'h00;
      start1 = 1'b0; sub1 = 1'b0; ci1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      step(); step();
      n_cmp++;
      if ({busy, done, s, co, ovf} !== 12'h000) begin
         n_bad++; $display("FAIL reset_outputs: busy=%b done=%b s=%h co=%b ovf=%b want all 0",
                           busy, done, s, co, ovf);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_add();
      check_op("add_c8_64", 8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0);
      // No start in the done cycle: back to idle, result held, no second done.
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || s !== 8'h2C) begin
         n_bad++; $display("FAIL idle_hold: done=%b busy=%b s=%h want 0 0 2c", done, busy, s);
      end
      step();
   endtask

   task automatic test_back_to_back();
      check_op("add_64_32", 8'h64, 8'h32, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
      // Started straight from the done cycle.
      check_op("add_ff_00_ci", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_sub();
      check_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
      check_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
      check_op("sub_10_03_bi", 8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0);
      step();
   endtask

   task automatic test_start_ignored();
      int dones;
      start = 1'b1; a = 8'h11; b = 8'h22; ci = 1'b0; sub = 1'b0;
      step();
      start = 1'b0;
      step(); step();   // now in busy cycle 3
      start = 1'b1; a = 8'hFF; b = 8'hFF; ci = 1'b1; sub = 1'b1;
      step();
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 14; i++) begin
         if (done) begin
            dones++;
            n_cmp++;
            if (s !== 8'h33 || co !== 1'b0 || ovf !== 1'b0) begin
               n_bad++; $display("FAIL ignore_result: s=%h co=%b ovf=%b want 33 0 0", s, co, ovf);
            end
         end
         step();
      end
      n_cmp++;
      if (dones !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
   endtask

   task automatic test_reset_midop();
      start = 1'b1; a = 8'h40; b = 8'h40; ci = 1'b0; sub = 1'b0;
      step();
      start = 1'b0;
      step(); step(); step();   // now in busy cycle 4
      n_cmp++;
      if (busy !== 1'b1 || s !== 8'h33) begin
         n_bad++; $display("FAIL pre_reset: busy=%b s=%h want 1 33", busy, s);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if ({busy, done, s, co, ovf} !== 12'h000) begin
         n_bad++; $display("FAIL midop_reset: busy=%b done=%b s=%h co=%b ovf=%b want all 0",
                           busy, done, s, co, ovf);
      end
      check_op("post_reset_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      step();
   endtask

   task automatic test_width1();
      logic [2:0] t;
      logic es, eco;
      for (int v = 7; v >= 0; v--) begin
         t = 3'(v);
         start1 = 1'b1; a1 = t[2]; b1 = t[1]; ci1 = t[0]; sub1 = 1'b0;
         step();
         start1 = 1'b0;
         n_cmp++;
         if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_bad++; $display("FAIL w1_busy_%0d: busy=%b done=%b want 1 0", v, busy1, done1);
         end
         step();
         es  = t[2] ^ t[1] ^ t[0];
         eco = (t[2] & t[1]) | (t[2] & t[0]) | (t[1] & t[0]);
         n_cmp++;
         if (done1 !== 1'b1 || s1 !== es || co1 !== eco || ovf1 !== (t[0] ^ eco)) begin
            n_bad++; $display("FAIL w1_fa_%0d: done=%b s=%b co=%b ovf=%b want 1 %b %b %b",
                              v, done1, s1, co1, ovf1, es, eco, t[0] ^ eco);
         end
         step();
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_add();
      test_back_to_back();
      test_sub();
      test_start_ignored();
      test_reset_midop();
      test_width1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
